// File: rtl/full_adder_unit_pkg.sv
// Shared bit-level equations for the full-adder cell, kept in one place so any
// future carry-lookahead variant can reuse the same primitives.
package full_adder_unit_pkg;

   // Sum bit of a single full-adder cell: odd parity of the three inputs.
   function automatic logic fa_sum(input logic a, input logic b, input logic cin);
      return a ^ b ^ cin;
   endfunction

   // Carry-out of a single cell: majority of the three inputs.
   function automatic logic fa_carry(input logic a, input logic b, input logic cin);
      return (a & b) | (a & cin) | (b & cin);
   endfunction

endpackage : full_adder_unit_pkg

// File: rtl/full_adder_unit_cell.sv
// 1-bit combinational full-adder cell; chained LSB-to-MSB by full_adder_unit.
module full_adder_cell
   import full_adder_unit_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = fa_sum(a, b, cin);
   assign cout = fa_carry(a, b, cin);

endmodule : full_adder_cell

// File: rtl/full_adder_unit.sv
// WIDTH-bit ripple-carry adder with a zero-latency result and a one-cycle
// registered copy qualified by out_valid.
module full_adder_unit #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic [WIDTH-1:0] sum_q,
   output logic             carry_q,
   output logic             out_valid
);

   logic [WIDTH:0]   w_chain;
   logic [WIDTH-1:0] r_sum_q;
   logic             r_carry_q;
   logic             r_out_valid;

   assign w_chain[0] = c;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder_cell u_cell (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (w_chain[gi]),
         .s    (sum[gi]),
         .cout (w_chain[gi+1])
      );
   end

   assign carry = w_chain[WIDTH];

   // Result registers hold when in_valid is low; only the valid flag drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum_q     <= '0;
         r_carry_q   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_sum_q   <= sum;
            r_carry_q <= carry;
         end
      end
   end

   assign sum_q     = r_sum_q;
   assign carry_q   = r_carry_q;
   assign out_valid = r_out_valid;

endmodule : full_adder_unit

// File: tb/tb_full_adder_unit.sv
// Self-checking bench: directed corner cases at WIDTH=1/4 plus random WIDTH=8
// traffic compared against plain integer arithmetic.
module tb_full_adder_unit;

   logic clk;
   logic rst_n;

   logic       a1, b1, c1, v1;
   logic       s1, co1, sq1, cq1, ov1;
   logic [3:0] a4, b4, s4, sq4;
   logic       c4, v4, co4, cq4, ov4;
   logic [7:0] a8, b8, s8, sq8;
   logic       c8, v8, co8, cq8, ov8;

   int n_tests;
   int n_fail;

   full_adder_unit #(.WIDTH(1)) u_dut_w1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a1),
      .b         (b1),
      .c         (c1),
      .in_valid  (v1),
      .sum       (s1),
      .carry     (co1),
      .sum_q     (sq1),
      .carry_q   (cq1),
      .out_valid (ov1)
   );

   full_adder_unit #(.WIDTH(4)) u_dut_w4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a4),
      .b         (b4),
      .c         (c4),
      .in_valid  (v4),
      .sum       (s4),
      .carry     (co4),
      .sum_q     (sq4),
      .carry_q   (cq4),
      .out_valid (ov4)
   );

   full_adder_unit #(.WIDTH(8)) u_dut_w8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a8),
      .b         (b8),
      .c         (c8),
      .in_valid  (v8),
      .sum       (s8),
      .carry     (co8),
      .sum_q     (sq8),
      .carry_q   (cq8),
      .out_valid (ov8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned ref_sum;
      logic [7:0]  exp_sq8;
      logic        exp_cq8;
      logic        exp_ov8;

      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0;
      {a1, b1, c1, v1} = '0;
      {a4, b4, c4, v4} = '0;
      {a8, b8, c8, v8} = '0;

      #2;
      check("rst_sq1", 64'(sq1), 64'd0);
      check("rst_cq1", 64'(cq1), 64'd0);
      check("rst_ov1", 64'(ov1), 64'd0);
      check("rst_sq4", 64'(sq4), 64'd0);
      check("rst_ov4", 64'(ov4), 64'd0);
      check("rst_sq8", 64'(sq8), 64'd0);
      check("rst_ov8", 64'(ov8), 64'd0);

      tick();
      rst_n = 1'b1;

      // WIDTH=1 exhaustive truth table
      for (int i = 0; i < 8; i++) begin
         {a1, b1, c1} = 3'(i);
         #10;
         ref_sum = 32'(a1) + 32'(b1) + 32'(c1);
         check("w1_truth", 64'({co1, s1}), 64'(ref_sum));
      end

      // WIDTH=4 wrap-around corners
      a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
      #1;
      check("w4_f_0_1_sum", 64'(s4), 64'h0);
      check("w4_f_0_1_carry", 64'(co4), 64'd1);
      a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
      #1;
      check("w4_7_8_0_sum", 64'(s4), 64'hF);
      check("w4_7_8_0_carry", 64'(co4), 64'd0);

      // WIDTH=4 single capture then hold
      tick();
      a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; v4 = 1'b1;
      tick();
      v4 = 1'b0; a4 = 4'h3; b4 = 4'h2; c4 = 1'b0;
      check("w4_cap_sq", 64'(sq4), 64'hF);
      check("w4_cap_cq", 64'(cq4), 64'd1);
      check("w4_cap_ov", 64'(ov4), 64'd1);
      tick();
      check("w4_hold_sq", 64'(sq4), 64'hF);
      check("w4_hold_cq", 64'(cq4), 64'd1);
      check("w4_hold_ov", 64'(ov4), 64'd0);

      // WIDTH=1 async reset mid-stream with in_valid held high
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
      tick();
      check("w1_pre_sq", 64'(sq1), 64'd1);
      check("w1_pre_ov", 64'(ov1), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("w1_arst_sq", 64'(sq1), 64'd0);
      check("w1_arst_cq", 64'(cq1), 64'd0);
      check("w1_arst_ov", 64'(ov1), 64'd0);
      check("w1_arst_comb", 64'({co1, s1}), 64'd3);
      tick();
      check("w1_rst_edge_sq", 64'(sq1), 64'd0);
      check("w1_rst_edge_ov", 64'(ov1), 64'd0);
      check("w1_rst_edge_comb", 64'({co1, s1}), 64'd3);
      v1 = 1'b0;
      rst_n = 1'b1;
      tick();
      check("w1_post_rel_ov", 64'(ov1), 64'd0);
      check("w1_post_rel_sq", 64'(sq1), 64'd0);
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      check("w1_recap_sq", 64'(sq1), 64'd1);
      check("w1_recap_cq", 64'(cq1), 64'd1);
      check("w1_recap_ov", 64'(ov1), 64'd1);

      // WIDTH=8 random traffic; model register starts from reset value
      exp_sq8 = '0;
      exp_cq8 = 1'b0;
      exp_ov8 = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 1'($urandom);
         // Occasional all-ones corners, mostly valid so back-to-back runs occur
         if ($urandom_range(0, 15) == 0) begin
            a8 = 8'hFF;
            b8 = 8'($urandom_range(0, 1) * 255);
         end
         v8 = ($urandom_range(0, 3) != 0);
         #1;
         ref_sum = 32'(a8) + 32'(b8) + 32'(c8);
         check("w8_comb", 64'({co8, s8}), 64'(ref_sum));
         if (v8) begin
            exp_sq8 = ref_sum[7:0];
            exp_cq8 = ref_sum[8];
         end
         exp_ov8 = v8;
         tick();
         check("w8_sum_q", 64'(sq8), 64'(exp_sq8));
         check("w8_carry_q", 64'(cq8), 64'(exp_cq8));
         check("w8_out_valid", 64'(ov8), 64'(exp_ov8));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_full_adder_unit
